// File: rtl/dti_arb_pkg.sv
// Shared types and helpers for the dti round-robin arbiter.
package dti_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LOCK = 2'd2
  } arb_state_t;

  // Modulo-num increment; keeps the pointer inside 0..num-1 for any num.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num);
    return (ptr + 32'd1 >= num) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo NUM.
// Purely combinational, no backpressure of its own.
module rr_prio_enc #(
  parameter int NUM  = 4,
  parameter int W_ID = $clog2(NUM)
) (
  input  logic [NUM-1:0]  req_i,
  input  logic [W_ID-1:0] ptr_i,
  output logic [W_ID-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [W_ID-1:0] idx;

  // Scan from the farthest offset down so the nearest request is written last.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      idx = W_ID'((int'(ptr_i) + k) % NUM);
      if (req_i[idx]) begin
        gnt_idx_o = idx;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dti_rr_arb.sv
// Round-robin arbiter of NUM dti requesters onto one producer, tagged {id, data}; 0-cycle forward path.
// Backpressure: dout ready goes only to the granted requester; grant is held while stalled or inside a locked packet.
module dti_rr_arb
  import dti_arb_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int W_DIN    = 16,
  parameter int LOCK_EOT = 0,
  parameter int W_ID     = $clog2(NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM-1:0]         din_vld_i,
  input  logic [NUM*W_DIN-1:0]   din_dat_i,
  output logic [NUM-1:0]         din_rdy_o,
  output logic                   dout_vld_o,
  output logic [W_ID+W_DIN-1:0]  dout_dat_o,
  input  logic                   dout_rdy_i,
  output logic [W_ID-1:0]        ptr_o,
  output logic [1:0]             state_o
);

  arb_state_t      state_q, state_d;
  logic [W_ID-1:0] owner_q, owner_d;
  logic [W_ID-1:0] ptr_q, ptr_d;
  logic [W_ID-1:0] sel, cur, cur_nxt;
  logic            any, cur_vld, xfer, eot;
  logic [W_DIN-1:0] cur_dat;

  rr_prio_enc #(
    .NUM  (NUM),
    .W_ID (W_ID)
  ) u_prio (
    .req_i     (din_vld_i),
    .ptr_i     (ptr_q),
    .gnt_idx_o (sel),
    .any_o     (any)
  );

  // Outside IDLE the owner is pinned so dout cannot change under a stall.
  assign cur     = (state_q == IDLE) ? sel : owner_q;
  assign cur_vld = (state_q == IDLE) ? any : din_vld_i[cur];
  assign cur_dat = din_dat_i[int'(cur)*W_DIN +: W_DIN];
  assign cur_nxt = W_ID'(rr_next(int'(cur), NUM));
  assign eot     = cur_dat[W_DIN-1];

  assign dout_vld_o = cur_vld & ~rst;
  assign dout_dat_o = {cur, cur_dat};
  assign xfer       = dout_vld_o & dout_rdy_i;

  always_comb begin
    din_rdy_o = '0;
    if (cur_vld && !rst) begin
      din_rdy_o[cur] = dout_rdy_i;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (xfer) begin
          if (LOCK_EOT == 0 || eot) begin
            ptr_d   = cur_nxt;
            state_d = IDLE;
          end else begin
            owner_d = cur;
            state_d = LOCK;
          end
        end else if (state_q == IDLE && any) begin
          owner_d = sel;
          state_d = HOLD;
        end
      end
      LOCK: begin
        if (xfer && eot) begin
          ptr_d   = cur_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_dti_rr_arb.sv
// Bench for dti_rr_arb: three instances (NUM=4 free-running, NUM=4 packet-locked, NUM=3)
// checked cycle by cycle against a grant/lock reference model, plus directed scenarios.
module tb_dti_rr_arb;
  import dti_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  vld  [3];
  logic [15:0] dat  [3][4];
  logic        ordy [3];
  logic [3:0]  rdy  [3];
  logic        ovld [3];
  logic [17:0] odat [3];
  logic [1:0]  optr [3];
  logic [1:0]  ost  [3];

  logic [63:0] a_dat, b_dat;
  logic [47:0] c_dat;
  logic [2:0]  c_rdy;

  assign a_dat  = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign b_dat  = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
  assign c_dat  = {dat[2][2], dat[2][1], dat[2][0]};
  assign rdy[2] = {1'b0, c_rdy};

  dti_rr_arb #(.NUM(4), .W_DIN(16), .LOCK_EOT(0)) u_a (
    .clk(clk), .rst(rst), .din_vld_i(vld[0]), .din_dat_i(a_dat), .din_rdy_o(rdy[0]),
    .dout_vld_o(ovld[0]), .dout_dat_o(odat[0]), .dout_rdy_i(ordy[0]),
    .ptr_o(optr[0]), .state_o(ost[0]));

  dti_rr_arb #(.NUM(4), .W_DIN(16), .LOCK_EOT(1)) u_b (
    .clk(clk), .rst(rst), .din_vld_i(vld[1]), .din_dat_i(b_dat), .din_rdy_o(rdy[1]),
    .dout_vld_o(ovld[1]), .dout_dat_o(odat[1]), .dout_rdy_i(ordy[1]),
    .ptr_o(optr[1]), .state_o(ost[1]));

  dti_rr_arb #(.NUM(3), .W_DIN(16), .LOCK_EOT(0)) u_c (
    .clk(clk), .rst(rst), .din_vld_i(vld[2][2:0]), .din_dat_i(c_dat), .din_rdy_o(c_rdy),
    .dout_vld_o(ovld[2]), .dout_dat_o(odat[2]), .dout_rdy_i(ordy[2]),
    .ptr_o(optr[2]), .state_o(ost[2]));

  int NUMS [3] = '{4, 4, 3};
  int LKS  [3] = '{0, 1, 0};

  // Reference model: who holds the grant (mode 0 = free, 1 = stalled, 2 = in packet).
  int m_ptr  [3] = '{0, 0, 0};
  int m_own  [3] = '{0, 0, 0};
  int m_mode [3] = '{0, 0, 0};

  logic        obs_vld [3];
  logic [17:0] obs_dat [3];
  logic [3:0]  obs_rdy [3];
  logic [1:0]  obs_ptr [3];
  logic [1:0]  obs_st  [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int d);
    int g;
    logic ev;
    logic [3:0] er, care;
    logic [15:0] w;
    arb_state_t es;
    obs_vld[d] = ovld[d];
    obs_dat[d] = odat[d];
    obs_rdy[d] = rdy[d];
    obs_ptr[d] = optr[d];
    obs_st[d]  = ost[d];
    es = (m_mode[d] == 2) ? LOCK : ((m_mode[d] == 1) ? HOLD : IDLE);
    chk($sformatf("state[%0d]", d), 32'(ost[d]), 32'(es));
    chk($sformatf("ptr[%0d]", d), 32'(optr[d]), 32'(m_ptr[d]));
    if (rst) begin
      chk($sformatf("rst_vld[%0d]", d), 32'(ovld[d]), 32'd0);
      chk($sformatf("rst_rdy[%0d]", d), 32'(rdy[d]), 32'd0);
      m_ptr[d] = 0; m_own[d] = 0; m_mode[d] = 0;
      return;
    end
    g = -1;
    if (m_mode[d] != 0) g = m_own[d];
    else
      for (int k = 0; k < NUMS[d]; k++)
        if (g < 0 && vld[d][(m_ptr[d] + k) % NUMS[d]]) g = (m_ptr[d] + k) % NUMS[d];
    ev   = (g >= 0) && vld[d][g];
    er   = ev ? (4'(ordy[d]) << g) : 4'b0;
    care = (!ev && g >= 0) ? ~(4'b0001 << g) : 4'hF;
    chk($sformatf("vld[%0d]", d), 32'(ovld[d]), 32'(ev));
    if (ev) chk($sformatf("dat[%0d]", d), 32'(odat[d]), 32'({2'(g), dat[d][g]}));
    chk($sformatf("rdy[%0d]", d), 32'(rdy[d] & care), 32'(er & care));
    if (ev && ordy[d]) begin
      w = dat[d][g];
      if (LKS[d] == 0 || w[15]) begin
        m_ptr[d] = (g + 1) % NUMS[d];
        m_mode[d] = 0;
      end else begin
        m_own[d] = g;
        m_mode[d] = 2;
      end
    end else if (m_mode[d] == 0 && g >= 0) begin
      m_own[d] = g;
      m_mode[d] = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int d = 0; d < 3; d++) begin
      vld[d] = 4'b0;
      for (int i = 0; i < 4; i++) dat[d][i] = 16'h0;
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [15:0] w);
    for (int d = 0; d < 3; d++) begin
      vld[d][i] = v;
      dat[d][i] = w;
    end
  endtask

  task automatic set_rdy(input logic r);
    for (int d = 0; d < 3; d++) ordy[d] = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    set_rdy(1'b1);
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd(input logic eot);
    return {eot, 15'($urandom)};
  endfunction

  initial begin
    rst = 1'b1;
    clear_in();
    set_rdy(1'b1);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_vld", 32'(obs_vld[0]), 32'd0);
    chk("reset_st", 32'(obs_st[0]), 32'(IDLE));

    // All four requesting, no backpressure: strict rotation.
    for (int i = 0; i < 4; i++) drive(i, 1'b1, rnd(1'b1));
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rot_id", 32'(obs_dat[0][17:16]), 32'(c % 4));
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < 4; i++)
          if (obs_rdy[d][i]) dat[d][i] = rnd(1'b1);
    end

    // Stalled grant stays on requester 2 while requester 0 arrives.
    do_reset();
    drive(2, 1'b1, 16'hAAAA);
    set_rdy(1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive(0, 1'b1, 16'h1234);
      tick();
      chk("hold_vld", 32'(obs_vld[0]), 32'd1);
      chk("hold_dat", 32'(obs_dat[0]), 32'h2AAAA);
    end
    set_rdy(1'b1);
    tick();
    chk("hold_xfer", 32'(obs_dat[0]), 32'h2AAAA);
    drive(2, 1'b0, 16'h0);
    tick();
    chk("hold_next", 32'(obs_dat[0][17:16]), 32'd0);

    // Packet lock: 3 words from requester 1 with a bubble, requester 3 waiting.
    do_reset();
    drive(1, 1'b1, 16'h0001);
    drive(3, 1'b1, 16'h8333);
    tick();
    chk("lock_w1", 32'(obs_dat[1][17:16]), 32'd1);
    chk("lock_r3a", 32'(obs_rdy[1][3]), 32'd0);
    drive(1, 1'b0, 16'h0);
    tick();
    chk("lock_bub", 32'(obs_vld[1]), 32'd0);
    chk("lock_r3b", 32'(obs_rdy[1][3]), 32'd0);
    drive(1, 1'b1, 16'h0002);
    tick();
    chk("lock_w2", 32'(obs_dat[1][17:16]), 32'd1);
    drive(1, 1'b1, 16'h8003);
    tick();
    chk("lock_w3", 32'(obs_dat[1]), 32'h18003);
    chk("lock_r3c", 32'(obs_rdy[1][3]), 32'd0);
    drive(1, 1'b0, 16'h0);
    tick();
    chk("lock_rel", 32'(obs_dat[1][17:16]), 32'd3);

    // NUM=3 wrap: grant to 2 sends ptr back to 0.
    do_reset();
    drive(2, 1'b1, 16'h8C00);
    tick();
    drive(0, 1'b1, 16'h8A00);
    drive(2, 1'b1, 16'h8C01);
    tick();
    chk("wrap_ptr", 32'(obs_ptr[2]), 32'd0);
    chk("wrap_id", 32'(obs_dat[2][17:16]), 32'd0);

    // Reset in the middle of a locked packet.
    do_reset();
    drive(1, 1'b1, 16'h0011);
    tick();
    chk("rstlk_st", 32'(obs_st[1]), 32'(IDLE));
    rst = 1'b1;
    drive(1, 1'b1, 16'h0012);
    tick();
    chk("rstlk_vld", 32'(obs_vld[1]), 32'd0);
    chk("rstlk_rdy", 32'(obs_rdy[1]), 32'd0);
    rst = 1'b0;
    drive(0, 1'b1, 16'h8100);
    drive(1, 1'b1, 16'h8101);
    tick();
    chk("rstlk_st2", 32'(obs_st[1]), 32'(IDLE));
    chk("rstlk_ptr", 32'(obs_ptr[1]), 32'd0);
    chk("rstlk_id", 32'(obs_dat[1][17:16]), 32'd0);

    // Idle for 10 cycles: pointer must not move.
    do_reset();
    drive(1, 1'b1, 16'h8001);
    tick();
    clear_in();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_vld", 32'(obs_vld[0]), 32'd0);
      chk("idle_rdy", 32'(obs_rdy[0]), 32'd0);
      chk("idle_ptr", 32'(obs_ptr[0]), 32'd2);
    end

    // Randomized protocol-respecting traffic on all three instances.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (vld[d][i] && obs_rdy[d][i]) begin
            vld[d][i] = ($urandom % 4) != 0;
            dat[d][i] = rnd(($urandom % 3) == 0);
          end else if (!vld[d][i]) begin
            vld[d][i] = ($urandom % 3) == 0;
            dat[d][i] = rnd(($urandom % 3) == 0);
          end
        end
        ordy[d] = ($urandom % 4) != 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
